// File: rtl/seq_multiplier_if.sv
// Handshake and data bundle for seq_multiplier.
//   start       : request, sampled only while busy=0
//   signed_mode : 1 = operands are two's-complement, 0 = unsigned
//   A, B        : multiplicand / multiplier, sampled with start
//   busy        : operation in progress
//   done        : one-cycle pulse, C holds a new product
//   C           : product register (2*WIDTH bits)
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 4
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     C;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, C
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, C
    );
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, unsigned or signed per operation.
// Operands are reduced to magnitudes on accept, multiplied over WIDTH
// iterations, and the sign is reapplied in a final FIX cycle.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low
//   bus   : start/signed_mode/A/B in, busy/done/C out (all outputs registered)
module seq_multiplier #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input logic             clk,
    input logic             rst_n,
    seq_multiplier_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH:0]     acc;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   c_q;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     acc_add;
    logic [2*WIDTH:0]     acc_next;

    always_comb begin
        // The most-negative operand negates to itself, which read unsigned
        // is exactly its magnitude 2^(WIDTH-1).
        mag_a    = (bus.signed_mode && bus.A[WIDTH-1]) ? ('0 - bus.A) : bus.A;
        mag_b    = (bus.signed_mode && bus.B[WIDTH-1]) ? ('0 - bus.B) : bus.B;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        acc_add  = mplier[0] ? {sum, acc[WIDTH-1:0]} : acc;
        acc_next = acc_add >> 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= StIdle;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            c_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= StCalc;
                    end
                end
                StCalc: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    // Magnitude product fits in 2*WIDTH bits, so negation is exact.
                    c_q    <= neg ? ('0 - acc[2*WIDTH-1:0]) : acc[2*WIDTH-1:0];
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.C    = c_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    seq_multiplier_if #(.WIDTH(4)) bus4 ();
    seq_multiplier_if #(.WIDTH(8)) bus8 ();

    seq_multiplier #(.WIDTH(4), .CNT_W(3)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    seq_multiplier #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as the mode defines them.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic sm);
        longint sa;
        longint sb;
        longint p;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 64'(p) & ((64'(1) << (2 * w)) - 64'(1));
    endfunction

    // Called at a negedge with busy=0. Returns at the negedge where done is seen.
    // With chain=1, start stays high during the operation carrying the next operands.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                       input bit chain, input logic [3:0] na, input logic [3:0] nb,
                       input logic nsm);
        logic [7:0] exp;
        logic [7:0] c_before;
        int lat;
        int busy_cnt;
        bit stable;
        exp = 8'(ref_mul(4, 32'(a), 32'(b), sm));
        c_before = bus4.C;
        bus4.start = 1'b1;
        bus4.A = a;
        bus4.B = b;
        bus4.signed_mode = sm;
        @(negedge clk);
        lat = 1;
        busy_cnt = 0;
        stable = 1'b1;
        if (chain) begin
            bus4.A = na;
            bus4.B = nb;
            bus4.signed_mode = nsm;
        end else begin
            bus4.start = 1'b0;
            bus4.A = 4'($urandom);
            bus4.B = 4'($urandom);
            bus4.signed_mode = 1'($urandom);
        end
        while (!bus4.done && lat < 20) begin
            if (bus4.busy) busy_cnt++;
            if (bus4.C !== c_before) stable = 1'b0;
            if (!chain && lat == 2) bus4.start = 1'b1;  // ignored while busy
            @(negedge clk);
            lat++;
        end
        if (!chain) bus4.start = 1'b0;
        check("lat4", 64'(lat), 64'd6);
        check("busy4", 64'(busy_cnt), 64'd5);
        check("hold4", 64'(stable), 64'd1);
        check("prod4", 64'(bus4.C), 64'(exp));
        check("busylow4", 64'(bus4.busy), 64'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        logic [15:0] exp;
        int lat;
        int busy_cnt;
        exp = 16'(ref_mul(8, 32'(a), 32'(b), sm));
        bus8.start = 1'b1;
        bus8.A = a;
        bus8.B = b;
        bus8.signed_mode = sm;
        @(negedge clk);
        bus8.start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!bus8.done && lat < 30) begin
            if (bus8.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check("lat8", 64'(lat), 64'd10);
        check("busy8", 64'(busy_cnt), 64'd9);
        check("prod8", 64'(bus8.C), 64'(exp));
    endtask

    initial begin
        logic [3:0] ca, cb, na, nb;
        logic cs, ns;
        int pulses;

        bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.A = '0; bus4.B = '0;
        bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.A = '0; bus8.B = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus4.busy), 64'd0);
        check("rst_done", 64'(bus4.done), 64'd0);
        check("rst_c", 64'(bus4.C), 64'd0);
        check("rst_c8", 64'(bus8.C), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        op4(4'd15, 4'd15, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        check("t1_e1", 64'(bus4.C), 64'hE1);
        op4(4'b1000, 4'b1000, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        check("t2_40", 64'(bus4.C), 64'h40);
        op4(4'b1000, 4'd7, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        check("t2_c8", 64'(bus4.C), 64'hC8);
        op4(4'hF, 4'd1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        check("t2_ff", 64'(bus4.C), 64'hFF);

        // Back-to-back with start held high
        op4(4'd3, 4'd5, 1'b0, 1'b1, 4'd2, 4'd6, 1'b0);
        check("t3_15", 64'(bus4.C), 64'd15);
        op4(4'd2, 4'd6, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        check("t3_12", 64'(bus4.C), 64'd12);

        // Reset on the third CALC edge
        bus4.start = 1'b1; bus4.A = 4'd9; bus4.B = 4'd9; bus4.signed_mode = 1'b0;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_busy", 64'(bus4.busy), 64'd0);
        check("mid_c", 64'(bus4.C), 64'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            if (bus4.done) pulses++;
            @(negedge clk);
        end
        check("mid_nodone", 64'(pulses), 64'd0);
        check("mid_c_after", 64'(bus4.C), 64'd0);
        op4(4'd1, 4'd1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        check("mid_next", 64'(bus4.C), 64'd1);

        // Exhaustive WIDTH=4, both modes
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 256; i++) begin
                op4(4'(i >> 4), 4'(i), 1'(m), 1'b0, 4'd0, 4'd0, 1'b0);
            end
        end

        // Random operands with random chaining
        ca = 4'($urandom); cb = 4'($urandom); cs = 1'($urandom);
        for (int i = 0; i < 60; i++) begin
            na = 4'($urandom); nb = 4'($urandom); ns = 1'($urandom);
            op4(ca, cb, cs, 1'($urandom_range(0, 1)), na, nb, ns);
            ca = na; cb = nb; cs = ns;
        end
        bus4.start = 1'b0;

        // WIDTH=8
        op8(8'h80, 8'h80, 1'b1);
        check("w8_4000", 64'(bus8.C), 64'h4000);
        op8(8'hFF, 8'hFF, 1'b0);
        check("w8_fe01", 64'(bus8.C), 64'hFE01);
        for (int i = 0; i < 30; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
